// File: rtl/rename_reg_file_pkg.sv
// Shared configuration and helpers for the rename register file and its checkpoint bank.
package rename_reg_file_pkg;

   localparam int XLEN_DEFAULT         = 32;
   localparam int ROB_SIZE_BIT_DEFAULT = 4;

   // How the live dependency table is rebuilt this cycle.
   typedef enum logic [1:0] {
      DEP_HOLD,
      DEP_CLEAR,
      DEP_RESTORE,
      DEP_UPDATE
   } dep_mode_e;

   function automatic dep_mode_e dep_mode(input logic rdy, input logic clr,
                                          input logic restore, input logic slot_live);
      dep_mode_e m;
      if (!rdy)
         m = DEP_HOLD;
      else if (clr || (restore && !slot_live))
         m = DEP_CLEAR;
      else if (restore)
         m = DEP_RESTORE;
      else
         m = DEP_UPDATE;
      return m;
   endfunction

endpackage

// File: rtl/rename_reg_file_dep_ckpt_bank.sv
// Snapshot storage for the dependency table: save, restore-read and commit-driven
// clearing of matching entries inside every live slot.
module dep_ckpt_bank
   import rename_reg_file_pkg::*;
#(
   parameter int NUM_REGS     = 32,
   parameter int ROB_SIZE_BIT = ROB_SIZE_BIT_DEFAULT,
   parameter int NUM_CMT      = 2,
   parameter int NUM_CKPT     = 4,
   localparam int REG_BITS    = $clog2(NUM_REGS),
   localparam int CKPT_BITS   = $clog2(NUM_CKPT)
) (
   input  logic                                     clk_in,
   input  logic                                     rst_in,
   input  logic                                     en,
   input  logic                                     clear_all,
   input  logic                                     save,
   input  logic                                     restore,
   input  logic [CKPT_BITS-1:0]                     id,
   input  logic [NUM_REGS-1:0]                      save_dep,
   input  logic [NUM_REGS-1:0][ROB_SIZE_BIT-1:0]    save_tag,
   input  logic [NUM_CMT-1:0]                       cmt_valid,
   input  logic [NUM_CMT-1:0][REG_BITS-1:0]         cmt_idx,
   input  logic [NUM_CMT-1:0][ROB_SIZE_BIT-1:0]     cmt_tag,
   output logic [NUM_REGS-1:0]                      slot_dep,
   output logic [NUM_REGS-1:0][ROB_SIZE_BIT-1:0]    slot_tag,
   output logic                                     slot_live,
   output logic [NUM_CKPT-1:0]                      ckpt_valid
);

   logic [NUM_CKPT-1:0]                   valid_q, valid_d;
   logic [NUM_REGS-1:0]                   dep_q [NUM_CKPT];
   logic [NUM_REGS-1:0]                   dep_d [NUM_CKPT];
   logic [NUM_REGS-1:0][ROB_SIZE_BIT-1:0] tag_q [NUM_CKPT];
   logic [NUM_REGS-1:0][ROB_SIZE_BIT-1:0] tag_d [NUM_CKPT];

   assign slot_dep   = dep_q[id];
   assign slot_tag   = tag_q[id];
   assign slot_live  = valid_q[id];
   assign ckpt_valid = valid_q;

   always_comb begin
      valid_d = valid_q;
      dep_d   = dep_q;
      tag_d   = tag_q;
      if (en) begin
         if (clear_all) begin
            valid_d = '0;
         end else begin
            for (int s = 0; s < NUM_CKPT; s++) begin
               for (int p = 0; p < NUM_CMT; p++) begin
                  if (valid_q[s] && cmt_valid[p] && tag_q[s][cmt_idx[p]] == cmt_tag[p]) begin
                     dep_d[s][cmt_idx[p]] = 1'b0;
                     tag_d[s][cmt_idx[p]] = '0;
                  end
               end
            end
            if (restore) begin
               valid_d[id] = 1'b0;
            end else if (save) begin
               dep_d[id]   = save_dep;
               tag_d[id]   = save_tag;
               valid_d[id] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_q <= '0;
         dep_q   <= '{default: '0};
         tag_q   <= '{default: '0};
      end else begin
         valid_q <= valid_d;
         dep_q   <= dep_d;
         tag_q   <= tag_d;
      end
   end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with producer-tag tracking, commit bypass on reads,
// and checkpointed dependency tables for branch recovery.
module rename_reg_file
   import rename_reg_file_pkg::*;
#(
   parameter int XLEN         = XLEN_DEFAULT,
   parameter int NUM_REGS     = 32,
   parameter int ROB_SIZE_BIT = ROB_SIZE_BIT_DEFAULT,
   parameter int NUM_RD       = 2,
   parameter int NUM_CMT      = 2,
   parameter int NUM_CKPT     = 4,
   localparam int REG_BITS    = $clog2(NUM_REGS),
   localparam int CKPT_BITS   = $clog2(NUM_CKPT)
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic                             rdy_in,
   input  logic                             rob_clear,
   input  logic [NUM_CMT-1:0]               cmt_valid,
   input  logic [NUM_CMT*REG_BITS-1:0]      cmt_idx,
   input  logic [NUM_CMT*XLEN-1:0]          cmt_val,
   input  logic [NUM_CMT*ROB_SIZE_BIT-1:0]  cmt_tag,
   input  logic [NUM_RD*REG_BITS-1:0]       rd_idx,
   output logic [NUM_RD*XLEN-1:0]           rd_val,
   output logic [NUM_RD-1:0]                rd_has_dep,
   output logic [NUM_RD*ROB_SIZE_BIT-1:0]   rd_tag,
   input  logic                             ren_valid,
   input  logic [REG_BITS-1:0]              ren_idx,
   input  logic [ROB_SIZE_BIT-1:0]          ren_tag,
   input  logic                             ckpt_save,
   input  logic                             ckpt_restore,
   input  logic [CKPT_BITS-1:0]             ckpt_id,
   output logic [NUM_CKPT-1:0]              ckpt_valid
);

   logic [XLEN-1:0]                       val_q [NUM_REGS];
   logic [XLEN-1:0]                       val_d [NUM_REGS];
   logic [NUM_REGS-1:0]                   dep_q, dep_d, base_dep;
   logic [NUM_REGS-1:0][ROB_SIZE_BIT-1:0] tag_q, tag_d, base_tag;

   logic [NUM_CMT-1:0][REG_BITS-1:0]      c_idx;
   logic [NUM_CMT-1:0][XLEN-1:0]          c_val;
   logic [NUM_CMT-1:0][ROB_SIZE_BIT-1:0]  c_tag;

   logic [NUM_REGS-1:0]                   slot_dep;
   logic [NUM_REGS-1:0][ROB_SIZE_BIT-1:0] slot_tag;
   logic                                  slot_live;
   dep_mode_e                             mode;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CMT; gi++) begin : g_cmt
         assign c_idx[gi] = cmt_idx[gi*REG_BITS +: REG_BITS];
         assign c_val[gi] = cmt_val[gi*XLEN +: XLEN];
         assign c_tag[gi] = cmt_tag[gi*ROB_SIZE_BIT +: ROB_SIZE_BIT];
      end
   endgenerate

   assign mode = dep_mode(rdy_in, rob_clear, ckpt_restore, slot_live);

   dep_ckpt_bank #(
      .NUM_REGS     (NUM_REGS),
      .ROB_SIZE_BIT (ROB_SIZE_BIT),
      .NUM_CMT      (NUM_CMT),
      .NUM_CKPT     (NUM_CKPT)
   ) u_ckpt (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .en         (rdy_in),
      .clear_all  (mode == DEP_CLEAR),
      .save       (ckpt_save),
      .restore    (ckpt_restore),
      .id         (ckpt_id),
      .save_dep   (dep_d),
      .save_tag   (tag_d),
      .cmt_valid  (cmt_valid),
      .cmt_idx    (c_idx),
      .cmt_tag    (c_tag),
      .slot_dep   (slot_dep),
      .slot_tag   (slot_tag),
      .slot_live  (slot_live),
      .ckpt_valid (ckpt_valid)
   );

   // Commits compare against the table being carried forward (live or restored snapshot).
   always_comb begin
      val_d    = val_q;
      dep_d    = dep_q;
      tag_d    = tag_q;
      base_dep = dep_q;
      base_tag = tag_q;
      if (mode == DEP_RESTORE) begin
         base_dep = slot_dep;
         base_tag = slot_tag;
      end
      if (mode != DEP_HOLD) begin
         for (int p = 0; p < NUM_CMT; p++) begin
            if (cmt_valid[p] && c_idx[p] != '0)
               val_d[c_idx[p]] = c_val[p];
         end
      end
      if (mode == DEP_CLEAR) begin
         dep_d = '0;
         tag_d = '0;
      end else if (mode == DEP_RESTORE || mode == DEP_UPDATE) begin
         dep_d = base_dep;
         tag_d = base_tag;
         for (int p = 0; p < NUM_CMT; p++) begin
            if (cmt_valid[p] && base_tag[c_idx[p]] == c_tag[p]) begin
               dep_d[c_idx[p]] = 1'b0;
               tag_d[c_idx[p]] = '0;
            end
         end
         if (mode == DEP_UPDATE && ren_valid && ren_idx != '0) begin
            dep_d[ren_idx] = 1'b1;
            tag_d[ren_idx] = ren_tag;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         val_q <= '{default: '0};
         dep_q <= '0;
         tag_q <= '0;
      end else begin
         val_q <= val_d;
         dep_q <= dep_d;
         tag_q <= tag_d;
      end
   end

   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [REG_BITS-1:0]     r_idx;
         logic [XLEN-1:0]         r_val;
         logic                    r_dep;
         logic [ROB_SIZE_BIT-1:0] r_tag;

         always_comb begin
            r_idx = rd_idx[gi*REG_BITS +: REG_BITS];
            r_val = val_q[r_idx];
            r_dep = dep_q[r_idx];
            r_tag = tag_q[r_idx];
            for (int p = 0; p < NUM_CMT; p++) begin
               if (cmt_valid[p] && c_idx[p] == r_idx && dep_q[r_idx] && c_tag[p] == tag_q[r_idx]) begin
                  r_val = c_val[p];
                  r_dep = 1'b0;
                  r_tag = '0;
               end
            end
            if (r_idx == '0) begin
               r_val = '0;
               r_dep = 1'b0;
               r_tag = '0;
            end
         end

         assign rd_val[gi*XLEN +: XLEN]                 = r_val;
         assign rd_has_dep[gi]                          = r_dep;
         assign rd_tag[gi*ROB_SIZE_BIT +: ROB_SIZE_BIT] = r_tag;
      end
   endgenerate

endmodule

// File: tb/tb_rename_reg_file.sv
// Randomized + directed bench; expected reads and checkpoint validity come from a
// table-level reference model and are checked by a decoupled monitor.
module tb_rename_reg_file;

   logic        clk = 1'b0;
   logic        rst_in, rdy_in, rob_clear;
   logic [1:0]  cmt_valid;
   logic [9:0]  cmt_idx;
   logic [63:0] cmt_val;
   logic [7:0]  cmt_tag;
   logic [9:0]  rd_idx;
   logic [63:0] rd_val;
   logic [1:0]  rd_has_dep;
   logic [7:0]  rd_tag;
   logic        ren_valid;
   logic [4:0]  ren_idx;
   logic [3:0]  ren_tag;
   logic        ckpt_save, ckpt_restore;
   logic [1:0]  ckpt_id;
   logic [3:0]  ckpt_valid;

   always #5 clk = ~clk;

   rename_reg_file dut (
      .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
      .cmt_valid(cmt_valid), .cmt_idx(cmt_idx), .cmt_val(cmt_val), .cmt_tag(cmt_tag),
      .rd_idx(rd_idx), .rd_val(rd_val), .rd_has_dep(rd_has_dep), .rd_tag(rd_tag),
      .ren_valid(ren_valid), .ren_idx(ren_idx), .ren_tag(ren_tag),
      .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .ckpt_id(ckpt_id),
      .ckpt_valid(ckpt_valid)
   );

   typedef struct packed {
      logic            rst, rdy, clr;
      logic [1:0]      cv;
      logic [1:0][4:0] ci;
      logic [1:0][31:0] cval;
      logic [1:0][3:0] ctag;
      logic [1:0][4:0] ri;
      logic            ren;
      logic [4:0]      ren_i;
      logic [3:0]      ren_t;
      logic            save, restore;
      logic [1:0]      id;
   } stim_t;

   typedef struct packed {
      logic        kind;     // 0 = read port, 1 = checkpoint valid vector
      logic        port;
      logic [31:0] val;
      logic        dep;
      logic [3:0]  tag;
      logic        chk_tag;
      logic [3:0]  ckv;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   // Reference model: plain arrays for the live table and each snapshot.
   logic [31:0] m_val [32];
   bit          m_dep [32];
   logic [3:0]  m_tag [32];
   bit          m_sv  [4];
   bit          m_sdep[4][32];
   logic [3:0]  m_stag[4][32];
   bit          m_known = 0;

   task automatic model_step(input stim_t s);
      bit         bdep [32];
      logic [3:0] btag [32];
      if (s.rst) begin
         for (int r = 0; r < 32; r++) begin
            m_val[r] = 0; m_dep[r] = 0; m_tag[r] = 0;
         end
         for (int k = 0; k < 4; k++) begin
            m_sv[k] = 0;
            for (int r = 0; r < 32; r++) begin m_sdep[k][r] = 0; m_stag[k][r] = 0; end
         end
         m_known = 1;
         return;
      end
      if (!s.rdy) return;
      for (int p = 0; p < 2; p++)
         if (s.cv[p] && s.ci[p] != 0) m_val[s.ci[p]] = s.cval[p];
      if (s.clr || (s.restore && !m_sv[s.id])) begin
         for (int r = 0; r < 32; r++) begin m_dep[r] = 0; m_tag[r] = 0; end
         for (int k = 0; k < 4; k++) m_sv[k] = 0;
         return;
      end
      for (int r = 0; r < 32; r++) begin
         bdep[r] = s.restore ? m_sdep[s.id][r] : m_dep[r];
         btag[r] = s.restore ? m_stag[s.id][r] : m_tag[r];
      end
      for (int r = 0; r < 32; r++) begin m_dep[r] = bdep[r]; m_tag[r] = btag[r]; end
      for (int p = 0; p < 2; p++)
         if (s.cv[p] && btag[s.ci[p]] == s.ctag[p]) begin
            m_dep[s.ci[p]] = 0; m_tag[s.ci[p]] = 0;
         end
      for (int k = 0; k < 4; k++)
         for (int p = 0; p < 2; p++)
            if (m_sv[k] && s.cv[p] && m_stag[k][s.ci[p]] == s.ctag[p]) begin
               m_sdep[k][s.ci[p]] = 0; m_stag[k][s.ci[p]] = 0;
            end
      if (s.restore) begin
         m_sv[s.id] = 0;
      end else begin
         if (s.ren && s.ren_i != 0) begin
            m_dep[s.ren_i] = 1; m_tag[s.ren_i] = s.ren_t;
         end
         if (s.save) begin
            for (int r = 0; r < 32; r++) begin
               m_sdep[s.id][r] = m_dep[r]; m_stag[s.id][r] = m_tag[r];
            end
            m_sv[s.id] = 1;
         end
      end
   endtask

   function automatic stim_t idle();
      stim_t s = '0;
      s.rdy = 1'b1;
      return s;
   endfunction

   task automatic do_cycle(input stim_t s, input string what);
      exp_t       e;
      logic [4:0] idx;
      rst_in = s.rst; rdy_in = s.rdy; rob_clear = s.clr;
      cmt_valid = s.cv; cmt_idx = s.ci; cmt_val = s.cval; cmt_tag = s.ctag;
      rd_idx = s.ri; ren_valid = s.ren; ren_idx = s.ren_i; ren_tag = s.ren_t;
      ckpt_save = s.save; ckpt_restore = s.restore; ckpt_id = s.id;
      if (m_known) begin
         for (int r = 0; r < 2; r++) begin
            e = '0;
            e.port = r[0];
            idx = s.ri[r];
            e.chk_tag = 1'b1;
            if (idx != 0) begin
               e.val = m_val[idx]; e.dep = m_dep[idx]; e.tag = m_tag[idx];
               for (int p = 0; p < 2; p++)
                  if (s.cv[p] && s.ci[p] == idx && m_dep[idx] && m_tag[idx] == s.ctag[p]) begin
                     e.val = s.cval[p]; e.dep = 1'b0; e.chk_tag = 1'b0;
                  end
            end
            exp_q.push_back(e);
         end
         e = '0;
         e.kind = 1'b1;
         for (int k = 0; k < 4; k++) e.ckv[k] = m_sv[k];
         exp_q.push_back(e);
      end
      $display("cyc %0d %s rst=%0b rdy=%0b clr=%0b cv=%b ren=%0b sv=%0b rs=%0b id=%0d rd=%0d/%0d",
               cyc, what, s.rst, s.rdy, s.clr, s.cv, s.ren, s.save, s.restore, s.id, s.ri[0], s.ri[1]);
      cyc++;
      @(posedge clk);
      model_step(s);
      #1;
   endtask

   // Monitor: outputs are settled at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (e.kind) begin
               if (ckpt_valid !== e.ckv) begin
                  miscompares++;
                  $display("FAIL ckpt_valid: got %b expected %b", ckpt_valid, e.ckv);
               end
            end else begin
               if (rd_val[e.port*32 +: 32] !== e.val || rd_has_dep[e.port] !== e.dep ||
                   (e.chk_tag && rd_tag[e.port*4 +: 4] !== e.tag)) begin
                  miscompares++;
                  $display("FAIL rd%0d: got val=%h dep=%b tag=%h expected val=%h dep=%b tag=%h",
                           e.port, rd_val[e.port*32 +: 32], rd_has_dep[e.port], rd_tag[e.port*4 +: 4],
                           e.val, e.dep, e.tag);
               end
            end
         end
      end
   end

   function automatic stim_t rand_stim();
      stim_t s = idle();
      s.rst = ($urandom_range(0, 199) == 0);
      s.rdy = ($urandom_range(0, 9) != 0);
      s.clr = ($urandom_range(0, 29) == 0);
      for (int p = 0; p < 2; p++) begin
         s.cv[p]   = $urandom_range(0, 1);
         s.ci[p]   = 5'($urandom_range(0, 7));
         s.cval[p] = $urandom;
         s.ctag[p] = $urandom_range(0, 1) ? m_tag[s.ci[p]] : 4'($urandom_range(0, 15));
      end
      s.ri[0]   = $urandom_range(0, 1) ? s.ci[0] : 5'($urandom_range(0, 7));
      s.ri[1]   = $urandom_range(0, 1) ? s.ci[1] : 5'($urandom_range(0, 31));
      s.ren     = $urandom_range(0, 1);
      s.ren_i   = 5'($urandom_range(0, 7));
      s.ren_t   = 4'($urandom_range(0, 15));
      s.save    = ($urandom_range(0, 5) == 0);
      s.restore = ($urandom_range(0, 11) == 0);
      s.id      = 2'($urandom_range(0, 3));
      return s;
   endfunction

   initial begin
      stim_t s;
      s = idle(); s.rst = 1'b1;
      do_cycle(s, "reset");
      s.ri[0] = 5; s.ri[1] = 9;
      do_cycle(s, "reset-read");

      // Rename then read, then commit with same-cycle bypass.
      s = idle(); s.ren = 1; s.ren_i = 5; s.ren_t = 3; do_cycle(s, "ren x5 t3");
      s = idle(); s.ri[0] = 5; do_cycle(s, "read x5");
      s = idle(); s.ri[0] = 5; s.ri[1] = 5; s.cv = 2'b01; s.ci[0] = 5; s.ctag[0] = 3; s.cval[0] = 32'hAA;
      do_cycle(s, "commit x5 bypass");
      s = idle(); s.ri[0] = 5; do_cycle(s, "read x5 after");

      // Older producer commit must not clear a newer rename.
      s = idle(); s.ren = 1; s.ren_i = 5; s.ren_t = 3; do_cycle(s, "ren x5 t3");
      s = idle(); s.ren = 1; s.ren_i = 5; s.ren_t = 7; do_cycle(s, "ren x5 t7");
      s = idle(); s.cv = 2'b01; s.ci[0] = 5; s.ctag[0] = 3; s.cval[0] = 1; s.ri[0] = 5;
      do_cycle(s, "commit x5 t3");
      s = idle(); s.ri[0] = 5; do_cycle(s, "read x5");

      // Same-index commits: younger port wins.
      s = idle(); s.cv = 2'b11; s.ci[0] = 6; s.ci[1] = 6; s.cval[0] = 1; s.cval[1] = 2;
      do_cycle(s, "dual commit x6");
      s = idle(); s.ri[0] = 6; do_cycle(s, "read x6");

      // Commit clears inside a saved snapshot, then restore.
      s = idle(); s.ren = 1; s.ren_i = 7; s.ren_t = 2; do_cycle(s, "ren x7 t2");
      s = idle(); s.save = 1; s.id = 1; do_cycle(s, "save 1");
      s = idle(); s.ren = 1; s.ren_i = 7; s.ren_t = 5; do_cycle(s, "ren x7 t5");
      s = idle(); s.cv = 2'b01; s.ci[0] = 7; s.ctag[0] = 2; s.cval[0] = 32'h77; do_cycle(s, "commit x7 t2");
      s = idle(); s.restore = 1; s.id = 1; s.ri[0] = 7; do_cycle(s, "restore 1");
      s = idle(); s.ri[0] = 7; do_cycle(s, "read x7");

      // Restore of an invalid slot flushes everything.
      s = idle(); s.cv = 2'b01; s.ci[0] = 8; s.cval[0] = 32'h88; do_cycle(s, "write x8");
      s = idle(); s.ren = 1; s.ren_i = 8; s.ren_t = 4; do_cycle(s, "ren x8 t4");
      s = idle(); s.ren = 1; s.ren_i = 9; s.ren_t = 6; s.save = 1; s.id = 2; do_cycle(s, "ren x9 save 2");
      s = idle(); s.restore = 1; s.id = 3; s.ri[0] = 8; s.ri[1] = 9; do_cycle(s, "restore invalid 3");
      s = idle(); s.ri[0] = 8; s.ri[1] = 9; do_cycle(s, "read x8 x9");

      // Stall holds all state; x0 stays zero.
      s = idle(); s.ren = 1; s.ren_i = 10; s.ren_t = 9; s.save = 1; s.id = 0; do_cycle(s, "ren x10 save 0");
      s = idle(); s.rdy = 0; s.clr = 1; s.cv = 2'b11; s.ci[0] = 10; s.ctag[0] = 9; s.cval[0] = 32'h55;
      s.ci[1] = 11; s.cval[1] = 32'h66; s.ren = 1; s.ren_i = 11; s.ren_t = 1; do_cycle(s, "stall");
      s = idle(); s.ri[0] = 10; s.ri[1] = 11; do_cycle(s, "read x10 x11");
      s = idle(); s.cv = 2'b01; s.ci[0] = 0; s.cval[0] = 32'h123; s.ren = 1; s.ren_i = 0; s.ren_t = 3;
      do_cycle(s, "write x0");
      s = idle(); s.ri[0] = 0; do_cycle(s, "read x0");

      // Reset wins over a simultaneous restore.
      s = idle(); s.rst = 1; s.restore = 1; s.id = 0; do_cycle(s, "reset+restore");
      s = idle(); s.ri[0] = 10; s.ri[1] = 8; do_cycle(s, "read after reset");

      for (int i = 0; i < 1000; i++) begin
         s = rand_stim();
         do_cycle(s, "rand");
      end

      s = idle();
      do_cycle(s, "drain");
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
